voice_recorder_top: RTL and testbench

//  FPGA top of a 1-bit microphone voice recorder. Samples the microphone bit stream on a divided sample tick and packs it into 16-bit words.

---
 rtl/voice_rec_pkg.sv | 30 +++
 rtl/voice_recorder_if.sv | 32 +++
 rtl/seg7_mux.sv | 48 ++++
 rtl/voice_recorder_top.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_voice_recorder_top.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/voice_rec_pkg.sv
// Shared types and constants for the 1-bit microphone voice recorder.
package voice_rec_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_e;

  // 7-segment glyphs, active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Block number (0 = none, 1, 2) to its digit glyph.
  function automatic logic [6:0] block_glyph(input logic [1:0] blk);
    case (blk)
      2'd1:    return SEG_1;
      2'd2:    return SEG_2;
      default: return SEG_0;
    endcase
  endfunction

endpackage

// File: rtl/voice_recorder_if.sv
// RAM-port and debug bundle of the voice recorder: word bus, address,
// per-block enables, timing pulses and the divided sample clock.
interface voice_recorder_if;
  import voice_rec_pkg::*;

  logic [WORD_W-1:0] memoryin;
  logic [WORD_W-1:0] data;
  logic [15:0]       memaddr;
  logic              block1ena;
  logic              block1wea;
  logic              block2ena;
  logic              block2wea;
  logic              timerdone;
  logic              timer;
  logic              donedes;
  logic              doneser;
  logic              done;
  logic              scaledclk;

  modport master (
    output memoryin, data, memaddr,
    output block1ena, block1wea, block2ena, block2wea,
    output timerdone, timer, donedes, doneser, done, scaledclk
  );

  modport slave (
    input memoryin, data, memaddr,
    input block1ena, block1wea, block2ena, block2wea,
    input timerdone, timer, donedes, doneser, done, scaledclk
  );

endinterface

// File: rtl/seg7_mux.sv
// Two-digit multiplexed 7-segment driver: a refresh down-counter alternates
// the active digit every REFRESH_DIV clocks. Anodes and cathodes active-low.
module seg7_mux
  import voice_rec_pkg::*;
#(
  parameter int REFRESH_DIV = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] glyph0,
  input  logic [6:0] glyph1,
  output logic       a0,
  output logic       a1,
  output logic [6:0] cathode
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] refresh_cnt;
  logic             slot;

  // Refresh timer: flip the active digit at terminal count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= CNT_W'(REFRESH_DIV - 1);
      slot        <= 1'b0;
    end else if (refresh_cnt == '0) begin
      refresh_cnt <= CNT_W'(REFRESH_DIV - 1);
      slot        <= ~slot;
    end else begin
      refresh_cnt <= refresh_cnt - 1'b1;
    end
  end

  // Registered anode/cathode drive so both change on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a0      <= 1'b1;
      a1      <= 1'b1;
      cathode <= SEG_BLANK;
    end else begin
      a0      <= slot;
      a1      <= ~slot;
      cathode <= slot ? glyph1 : glyph0;
    end
  end

endmodule

// File: rtl/voice_recorder_top.sv
// FPGA top of a 1-bit microphone voice recorder. Samples the mic on a
// divided tick, packs 16-bit words into one of two RAM blocks and plays
// them back serially on audio_out.
// Build option PLAYBACK_LOOP_EN: when defined, playback wraps to word 0 and
// keeps going until a new play edge or the latched switch drops.
//
// state  | meaning
// IDLE   | waiting for record/play rising edge with a block selected
// RECORD | sampling mic each tick, one RAM write per 16 samples
// PLAY   | fetching words and shifting them out MSB-first per tick
module voice_recorder_top
  import voice_rec_pkg::*;
#(
  parameter int CLK_DIV     = 50,
  parameter int MEM_DEPTH   = 4096,
  parameter int REFRESH_DIV = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       switch0,
  input  logic       switch1,
  input  logic       record,
  input  logic       play,
  input  logic       microphone,
  output logic       audio_out,
  output logic       a0,
  output logic       a1,
  output logic [6:0] cathode,
  voice_recorder_if.master dbg
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_RECORD = RECORD;
  localparam logic [1:0] S_PLAY   = PLAY;

  // Playback sub-phases: RAM read issued, word on data, shifting, last bit hold.
  localparam logic [1:0] P_WAIT  = 2'd0;
  localparam logic [1:0] P_READY = 2'd1;
  localparam logic [1:0] P_SHIFT = 2'd2;
  localparam logic [1:0] P_DRAIN = 2'd3;

  localparam int         DIV_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int         ADDR_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [3:0] BIT_LAST  = 4'(WORD_W - 1);

  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic              sclk_q;

  logic [1:0]        state;
  logic [1:0]        play_ph;
  logic [1:0]        sel_q;
  logic [1:0]        sel_now;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        bit_cnt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] memoryin_q;
  logic [WORD_W-1:0] data_q;
  logic              audio_q;
  logic              b1ena, b1wea, b2ena, b2wea;
  logic              donedes_q, doneser_q, done_q, timerdone_q;
  logic              record_q, play_q;
  logic              rec_rise, play_rise;

  logic [WORD_W-1:0] mem1 [MEM_DEPTH];
  logic [WORD_W-1:0] mem2 [MEM_DEPTH];

  assign sel_now   = switch0 ? 2'd1 : (switch1 ? 2'd2 : 2'd0);
  assign rec_rise  = record & ~record_q;
  assign play_rise = play & ~play_q;

`ifdef PLAYBACK_LOOP_EN
  logic latched_sw;
  assign latched_sw = (sel_q == 2'd1) ? switch0 : switch1;
`endif

  // Sample-tick divider; scaledclk rises with tick and falls half-way through.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt <= DIV_W'(CLK_DIV - 1);
      tick    <= 1'b0;
      sclk_q  <= 1'b0;
    end else if (div_cnt == '0) begin
      div_cnt <= DIV_W'(CLK_DIV - 1);
      tick    <= 1'b1;
      sclk_q  <= 1'b1;
    end else begin
      div_cnt <= div_cnt - 1'b1;
      tick    <= 1'b0;
      if (div_cnt == DIV_W'(CLK_DIV / 2)) sclk_q <= 1'b0;
    end
  end

  // Main sequencer: start decode, record packing, playback serializing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      play_ph     <= P_WAIT;
      sel_q       <= 2'd0;
      addr        <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      memoryin_q  <= '0;
      audio_q     <= 1'b0;
      b1ena       <= 1'b0;
      b1wea       <= 1'b0;
      b2ena       <= 1'b0;
      b2wea       <= 1'b0;
      donedes_q   <= 1'b0;
      doneser_q   <= 1'b0;
      done_q      <= 1'b0;
      timerdone_q <= 1'b0;
      record_q    <= 1'b0;
      play_q      <= 1'b0;
    end else begin
      record_q    <= record;
      play_q      <= play;
      donedes_q   <= 1'b0;
      doneser_q   <= 1'b0;
      done_q      <= 1'b0;
      timerdone_q <= 1'b0;
      b1ena       <= 1'b0;
      b1wea       <= 1'b0;
      b2ena       <= 1'b0;
      b2wea       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rec_rise && sel_now != 2'd0) begin
            state   <= S_RECORD;
            sel_q   <= sel_now;
            addr    <= '0;
            bit_cnt <= BIT_LAST;
          end else if (play_rise && sel_now != 2'd0) begin
            state   <= S_PLAY;
            sel_q   <= sel_now;
            addr    <= '0;
            play_ph <= P_WAIT;
            b1ena   <= (sel_now == 2'd1);
            b2ena   <= (sel_now == 2'd2);
          end
        end
        S_RECORD: begin
          // the word presented during donedes is written on this edge
          if (donedes_q) begin
            if (addr == ADDR_LAST) begin
              timerdone_q <= 1'b1;
              done_q      <= 1'b1;
              addr        <= '0;
              state       <= S_IDLE;
            end else begin
              addr <= addr + 1'b1;
            end
          end
          if (tick) begin
            shreg <= {shreg[WORD_W-2:0], microphone};
            if (bit_cnt == 4'd0) begin
              donedes_q  <= 1'b1;
              memoryin_q <= {shreg[WORD_W-2:0], microphone};
              b1ena      <= (sel_q == 2'd1);
              b1wea      <= (sel_q == 2'd1);
              b2ena      <= (sel_q == 2'd2);
              b2wea      <= (sel_q == 2'd2);
              bit_cnt    <= BIT_LAST;
            end else begin
              bit_cnt <= bit_cnt - 4'd1;
            end
          end
        end
        S_PLAY: begin
          case (play_ph)
            P_WAIT: play_ph <= P_READY;
            P_READY: begin
              if (tick) begin
                audio_q <= data_q[WORD_W-1];
                shreg   <= {data_q[WORD_W-2:0], 1'b0};
                bit_cnt <= BIT_LAST;
                play_ph <= P_SHIFT;
              end
            end
            P_SHIFT: begin
              if (tick) begin
                audio_q <= shreg[WORD_W-1];
                shreg   <= {shreg[WORD_W-2:0], 1'b0};
                bit_cnt <= bit_cnt - 4'd1;
                if (bit_cnt == 4'd1) begin
                  doneser_q <= 1'b1;
                  if (addr == ADDR_LAST) begin
`ifdef PLAYBACK_LOOP_EN
                    addr    <= '0;
                    b1ena   <= (sel_q == 2'd1);
                    b2ena   <= (sel_q == 2'd2);
                    play_ph <= P_WAIT;
`else
                    play_ph <= P_DRAIN;
`endif
                  end else begin
                    addr    <= addr + 1'b1;
                    b1ena   <= (sel_q == 2'd1);
                    b2ena   <= (sel_q == 2'd2);
                    play_ph <= P_WAIT;
                  end
                end
              end
            end
            default: begin
              // hold the final bit for a full tick, then finish
              if (tick) begin
                audio_q <= 1'b0;
                done_q  <= 1'b1;
                addr    <= '0;
                state   <= S_IDLE;
              end
            end
          endcase
`ifdef PLAYBACK_LOOP_EN
          if (play_rise || !latched_sw) begin
            audio_q   <= 1'b0;
            done_q    <= 1'b1;
            doneser_q <= 1'b0;
            addr      <= '0;
            b1ena     <= 1'b0;
            b2ena     <= 1'b0;
            state     <= S_IDLE;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM write ports; contents survive reset.
  always_ff @(posedge clock) begin
    if (b1ena && b1wea) mem1[addr] <= memoryin_q;
    if (b2ena && b2wea) mem2[addr] <= memoryin_q;
  end

  // RAM read: one-cycle latency onto data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else if (b1ena && !b1wea) begin
      data_q <= mem1[addr];
    end else if (b2ena && !b2wea) begin
      data_q <= mem2[addr];
    end
  end

  logic [1:0] disp_blk;
  logic [6:0] glyph0;
  logic [6:0] glyph1;

  assign disp_blk = (state == S_IDLE) ? sel_now : sel_q;
  assign glyph0   = block_glyph(disp_blk);
  assign glyph1   = (state == S_RECORD) ? SEG_R :
                    (state == S_PLAY)   ? SEG_P : SEG_DASH;

  seg7_mux #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_seg7 (
    .clock   (clock),
    .reset   (reset),
    .glyph0  (glyph0),
    .glyph1  (glyph1),
    .a0      (a0),
    .a1      (a1),
    .cathode (cathode)
  );

  assign audio_out     = audio_q;
  assign dbg.memoryin  = memoryin_q;
  assign dbg.data      = data_q;
  assign dbg.memaddr   = 16'(addr);
  assign dbg.block1ena = b1ena;
  assign dbg.block1wea = b1wea;
  assign dbg.block2ena = b2ena;
  assign dbg.block2wea = b2wea;
  assign dbg.timerdone = timerdone_q;
  assign dbg.timer     = (state != S_IDLE);
  assign dbg.donedes   = donedes_q;
  assign dbg.doneser   = doneser_q;
  assign dbg.done      = done_q;
  assign dbg.scaledclk = sclk_q;

endmodule

// File: tb/tb_voice_recorder_top.sv
// Directed bench for voice_recorder_top with CLK_DIV=4, MEM_DEPTH=4, REFRESH_DIV=8.
module tb_voice_recorder_top;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       switch0 = 1'b0;
  logic       switch1 = 1'b0;
  logic       record = 1'b0;
  logic       play = 1'b0;
  logic       microphone = 1'b0;
  logic       audio_out;
  logic       a0, a1;
  logic [6:0] cathode;

  voice_recorder_if dbg ();

  voice_recorder_top #(
    .CLK_DIV(4),
    .MEM_DEPTH(4),
    .REFRESH_DIV(8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .switch0    (switch0),
    .switch1    (switch1),
    .record     (record),
    .play       (play),
    .microphone (microphone),
    .audio_out  (audio_out),
    .a0         (a0),
    .a1         (a1),
    .cathode    (cathode),
    .dbg        (dbg)
  );

  always #5 clock = ~clock;

  int   n_vec = 0;
  int   n_err = 0;
  logic alt_mode = 1'b0;
  logic mic_next = 1'b1;
  logic sclk_prev = 1'b0;
  logic sclk_rose = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock, sampled at the falling edge; a new mic bit is driven on each tick.
  task automatic step();
    @(negedge clock);
    sclk_rose = dbg.scaledclk && !sclk_prev;
    if (sclk_rose) begin
      microphone = alt_mode ? mic_next : 1'b1;
      mic_next   = ~mic_next;
    end
    sclk_prev = dbg.scaledclk;
  endtask

  task automatic wait_sclk_rise(input string tag);
    int g = 0;
    do begin
      step();
      g++;
    end while (!sclk_rose && g < 100);
    chk({tag, "_sclk_rise"}, 32'(sclk_rose), 32'd1);
  endtask

  task automatic pulse_rec(input logic with_play);
    wait_sclk_rise("pulse");
    record   = 1'b1;
    play     = with_play;
    mic_next = 1'b1;
    step();
    record = 1'b0;
    play   = 1'b0;
  endtask

  task automatic pulse_play();
    play = 1'b1;
    step();
    play = 1'b0;
  endtask

  task automatic run_record(input string tag, input logic [15:0] exp_word, input logic blk2);
    int   k = 0;
    int   cyc = 0;
    logic other = 1'b0;
    logic got = 1'b0;
    logic disp_r = 1'b0;
    logic disp_b = 1'b0;
    while (!got && cyc < 2000) begin
      step();
      cyc++;
      other |= blk2 ? (dbg.block1ena | dbg.block1wea) : (dbg.block2ena | dbg.block2wea);
      if (dbg.donedes) begin
        chk({tag, "_memoryin"}, 32'(dbg.memoryin), 32'(exp_word));
        chk({tag, "_wea"}, 32'(blk2 ? dbg.block2wea : dbg.block1wea), 32'd1);
        chk({tag, "_memaddr"}, 32'(dbg.memaddr), 32'(k));
        k++;
      end
      if (!disp_r && !a1) begin
        chk({tag, "_disp_r"}, 32'(cathode), 32'h2F);
        disp_r = 1'b1;
      end
      if (!disp_b && !a0) begin
        chk({tag, "_disp_blk"}, 32'(cathode), blk2 ? 32'h24 : 32'h79);
        disp_b = 1'b1;
      end
      if (dbg.done) begin
        got = 1'b1;
        chk({tag, "_timerdone"}, 32'(dbg.timerdone), 32'd1);
      end
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_words"}, 32'(k), 32'd4);
    chk({tag, "_other_blk"}, 32'(other), 32'd0);
    step();
    chk({tag, "_timer_idle"}, 32'(dbg.timer), 32'd0);
    chk({tag, "_addr_idle"}, 32'(dbg.memaddr), 32'd0);
  endtask

  task automatic run_play(input string tag, input int exp_high, input int exp_rises,
                          input logic [15:0] exp_data, input logic blk2);
    int   cyc = 0;
    int   high = 0;
    int   rises = 0;
    int   sers = 0;
    logic prev_a = 1'b0;
    logic got = 1'b0;
    logic other = 1'b0;
    logic disp_p = 1'b0;
    pulse_play();
    chk({tag, "_timer_busy"}, 32'(dbg.timer), 32'd1);
    while (!got && cyc < 2000) begin
      step();
      cyc++;
      other |= blk2 ? dbg.block1ena : dbg.block2ena;
      if (dbg.doneser) sers++;
      if (dbg.done) begin
        got = 1'b1;
        chk({tag, "_audio_end"}, 32'(audio_out), 32'd0);
        chk({tag, "_data"}, 32'(dbg.data), 32'(exp_data));
      end else begin
        if (audio_out) high++;
        if (audio_out && !prev_a) rises++;
      end
      prev_a = audio_out;
      if (!disp_p && !a1) begin
        chk({tag, "_disp_p"}, 32'(cathode), 32'h0C);
        disp_p = 1'b1;
      end
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_high_clks"}, 32'(high), 32'(exp_high));
    chk({tag, "_rises"}, 32'(rises), 32'(exp_rises));
    chk({tag, "_doneser"}, 32'(sers), 32'd4);
    chk({tag, "_other_blk"}, 32'(other), 32'd0);
    chk({tag, "_addr_end"}, 32'(dbg.memaddr), 32'd0);
  endtask

  initial begin
    time t0;

    // reset state
    repeat (3) @(negedge clock);
    chk("rst_timer", 32'(dbg.timer), 32'd0);
    chk("rst_memaddr", 32'(dbg.memaddr), 32'd0);
    chk("rst_memoryin", 32'(dbg.memoryin), 32'd0);
    chk("rst_data", 32'(dbg.data), 32'd0);
    chk("rst_audio", 32'(audio_out), 32'd0);
    chk("rst_sclk", 32'(dbg.scaledclk), 32'd0);
    chk("rst_ena", 32'({dbg.block1ena, dbg.block1wea, dbg.block2ena, dbg.block2wea}), 32'd0);
    chk("rst_pulses", 32'({dbg.done, dbg.donedes, dbg.doneser, dbg.timerdone}), 32'd0);
    chk("rst_anodes", 32'({a0, a1}), 32'd3);
    chk("rst_cathode", 32'(cathode), 32'h7F);
    reset = 1'b1;

    // sample clock period
    wait_sclk_rise("period_a");
    t0 = $time;
    wait_sclk_rise("period_b");
    chk("sclk_period", 32'($time - t0), 32'd40);

    // record block 1, constant 1
    switch0  = 1'b1;
    alt_mode = 1'b0;
    pulse_rec(1'b0);
    run_record("rec1", 16'hFFFF, 1'b0);

    // play block 1
    run_play("play1", 256, 1, 16'hFFFF, 1'b0);

    // record block 2, alternating mic
    switch0  = 1'b0;
    switch1  = 1'b1;
    alt_mode = 1'b1;
    pulse_rec(1'b0);
    run_record("rec2", 16'hAAAA, 1'b1);

    // play block 2
    run_play("play2", 128, 32, 16'hAAAA, 1'b1);

    // no block selected: start ignored
    switch1  = 1'b0;
    alt_mode = 1'b0;
    pulse_rec(1'b0);
    repeat (20) step();
    chk("nosel_timer", 32'(dbg.timer), 32'd0);
    chk("nosel_memaddr", 32'(dbg.memaddr), 32'd0);

    // record+play together: record wins; mid-run switch change ignored
    switch0 = 1'b1;
    pulse_rec(1'b1);
    switch0 = 1'b0;
    switch1 = 1'b1;
    run_record("both", 16'hFFFF, 1'b0);
    switch1 = 1'b0;

    // reset mid-record
    switch0 = 1'b1;
    pulse_rec(1'b0);
    repeat (79) step();
    chk("mid_memaddr", 32'(dbg.memaddr), 32'd1);
    chk("mid_timer", 32'(dbg.timer), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_timer", 32'(dbg.timer), 32'd0);
    chk("arst_memaddr", 32'(dbg.memaddr), 32'd0);
    chk("arst_sclk", 32'(dbg.scaledclk), 32'd0);
    chk("arst_anodes", 32'({a0, a1}), 32'd3);
    chk("arst_cathode", 32'(cathode), 32'h7F);
    repeat (3) step();
    reset = 1'b1;
    pulse_rec(1'b0);
    run_record("rerec", 16'hFFFF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
